// File: rtl/mod_subtractor_pkg.sv
// Shared definitions for the serial 512-bit modular subtractor: state encoding,
// operand width and the chunk-count / counter-width helpers derived from CHUNK.
package mod_subtractor_pkg;

  localparam int unsigned WIDTH = 512;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_SUB  = 3'd2,
    S_ADD  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  function automatic int unsigned num_chunks(input int unsigned chunk);
    return WIDTH / chunk;
  endfunction

  function automatic int unsigned cnt_width(input int unsigned chunk);
    return (num_chunks(chunk) > 1) ? $clog2(num_chunks(chunk)) : 1;
  endfunction

endpackage

// File: rtl/mod_subtractor_chunk_addsub.sv
// CHUNK-bit adder with optional inversion of y; used for both the a - b pass
// (invert_y = 1, cin = 1 on the first chunk) and the + m correction pass.
module chunk_addsub #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             cin,
  input  logic             invert_y,
  output logic [CHUNK-1:0] sum,
  output logic             cout
);

  logic [CHUNK-1:0] y_eff;

  assign y_eff       = invert_y ? ~y : y;
  assign {cout, sum} = {1'b0, x} + {1'b0, y_eff} + {{CHUNK{1'b0}}, cin};

endmodule

// File: rtl/mod_subtractor.sv
// Serial (a - b) mod m over 512-bit operands, CHUNK bits per cycle: one
// subtract pass, then an add-m pass only when the subtract borrowed.
module mod_subtractor
  import mod_subtractor_pkg::*;
#(
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_m,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             busy
);

  localparam int unsigned N  = num_chunks(CHUNK);
  localparam int unsigned CW = cnt_width(CHUNK);
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t           state, next_state;
  logic [WIDTH-1:0] op_x, op_y, m_reg, r_reg, r_shift;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             last;
  logic [CHUNK-1:0] sum;
  logic             cout;

  assign last    = (cnt == LAST);
  assign r_shift = {sum, r_reg[WIDTH-1:CHUNK]};
  assign result  = r_reg;

  // The only adder: inverted subtrahend in SUB, plain modulus in ADD.
  chunk_addsub #(.CHUNK(CHUNK)) u_addsub (
    .x        (op_x[CHUNK-1:0]),
    .y        (op_y[CHUNK-1:0]),
    .cin      (carry),
    .invert_y (state == S_SUB),
    .sum      (sum),
    .cout     (cout)
  );

  // NOTE: state and datapath registers use non-blocking assignments so every
  // flop samples pre-edge values; blocking here would chain updates within one edge.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= next_state;
  end

  // NOTE: next_state gets its default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:  if (start) next_state = S_LOAD;
      S_LOAD:  next_state = S_SUB;
      S_SUB:   if (last) next_state = cout ? S_DONE : S_ADD;
      S_ADD:   if (last) next_state = S_DONE;
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // NOTE: the wide shift registers are cleared on reset too, so result reads 0
  // after an aborted operation instead of a half-computed difference.
  always_ff @(posedge clk) begin
    if (reset) begin
      op_x  <= '0;
      op_y  <= '0;
      m_reg <= '0;
      r_reg <= '0;
      cnt   <= '0;
      carry <= 1'b0;
      done  <= 1'b0;
      busy  <= 1'b0;
    end else begin
      done <= (next_state == S_DONE);
      busy <= (next_state != S_IDLE);
      case (state)
        S_LOAD: begin
          op_x  <= in_a;
          op_y  <= in_b;
          m_reg <= in_m;
          cnt   <= '0;
          carry <= 1'b1;
        end
        S_SUB: begin
          r_reg <= r_shift;
          cnt   <= last ? '0 : cnt + 1'b1;
          if (last && !cout) begin
            // Borrow: restart from the LSB chunk with r + m.
            op_x  <= r_shift;
            op_y  <= m_reg;
            carry <= 1'b0;
          end else begin
            op_x  <= op_x >> CHUNK;
            op_y  <= op_y >> CHUNK;
            carry <= cout;
          end
        end
        S_ADD: begin
          r_reg <= r_shift;
          cnt   <= last ? '0 : cnt + 1'b1;
          op_x  <= op_x >> CHUNK;
          op_y  <= op_y >> CHUNK;
          carry <= cout;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mod_subtractor.sv
// Scoreboard bench: one CHUNK=4 instance runs the directed scenarios while two
// CHUNK=8 instances with start held high run 500 random operations each.
module tb_mod_subtractor;
  import mod_subtractor_pkg::*;

  localparam int W        = WIDTH;
  localparam int N4       = W / 4;
  localparam int N8       = W / 8;
  localparam int RAND_OPS = 500;

  typedef logic [W-1:0] word_t;
  typedef struct {
    word_t res;
    int    lat;
    int    start_edge;
  } exp_t;

  logic clk = 1'b0;
  logic reset4 = 1'b1;
  logic reset8 = 1'b1;
  int   cyc = 0;
  int   n_compared = 0;
  int   n_mismatched = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input word_t got, input word_t want);
    n_compared++;
    if (got !== want) begin
      n_mismatched++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  task automatic check_int(input string name, input int got, input int want);
    n_compared++;
    if (got != want) begin
      n_mismatched++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  // Reference: true modular difference of values already reduced below m.
  function automatic word_t ref_mod_sub(input word_t a, input word_t b, input word_t m);
    logic [W:0] d;
    if (a >= b) d = {1'b0, a} - {1'b0, b};
    else        d = {1'b0, a} + {1'b0, m} - {1'b0, b};
    return d[W-1:0];
  endfunction

  // Edge at which done is sampled high, counted from the edge that took start.
  function automatic int ref_latency(input word_t a, input word_t b, input int n);
    return (a >= b) ? n + 2 : 2 * n + 2;
  endfunction

  function automatic word_t rand_word();
    word_t w;
    for (int i = 0; i < W / 32; i++) w[i*32 +: 32] = $urandom;
    return w;
  endfunction

  // ---------------- CHUNK = 4 lane: directed scenarios ----------------
  logic  s4_start = 1'b0;
  word_t s4_a = '0, s4_b = '0, s4_m = '0;
  word_t s4_result;
  logic  s4_done, s4_busy;
  exp_t  q4[$];

  mod_subtractor #(.CHUNK(4)) u_dut4 (
    .clk    (clk),
    .reset  (reset4),
    .start  (s4_start),
    .in_a   (s4_a),
    .in_b   (s4_b),
    .in_m   (s4_m),
    .result (s4_result),
    .done   (s4_done),
    .busy   (s4_busy)
  );

  initial begin : mon4
    exp_t e;
    bit   d_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (s4_done) begin
        check_int("lane4 done pulse width", int'(d_prev), 0);
        check_int("lane4 done with pending op", int'(q4.size() > 0), 1);
        if (q4.size() > 0) begin
          e = q4.pop_front();
          check("lane4 result", s4_result, e.res);
          check_int("lane4 done edge", cyc + 1, e.start_edge + e.lat);
        end
      end
      d_prev = s4_done;
    end
  end

  // Called at a negedge; start is sampled by the next rising edge.
  task automatic run4(input word_t a, input word_t b, input word_t m, input bit scramble);
    exp_t e;
    s4_a = a; s4_b = b; s4_m = m; s4_start = 1'b1;
    e.res = ref_mod_sub(a, b, m);
    e.lat = ref_latency(a, b, N4);
    e.start_edge = cyc + 1;
    q4.push_back(e);
    @(negedge clk);
    s4_start = 1'b0;
    @(negedge clk);
    if (scramble) begin
      s4_a = rand_word(); s4_b = rand_word(); s4_m = rand_word();
    end
    for (int i = 0; i < 600 && s4_busy; i++) @(negedge clk);
    check_int("lane4 operation finished", int'(s4_busy), 0);
    repeat (5) @(negedge clk);
    check("lane4 result held in idle", s4_result, e.res);
  endtask

  // ---------------- CHUNK = 8 lanes: random, start held high ----------------
  for (genvar g = 0; g < 2; g++) begin : g_rand
    logic  start = 1'b0;
    word_t a = '0, b = '0, m = '0;
    word_t result;
    logic  done, busy;
    bit    finished = 1'b0;
    exp_t  q[$];

    mod_subtractor #(.CHUNK(8)) u_dut8 (
      .clk    (clk),
      .reset  (reset8),
      .start  (start),
      .in_a   (a),
      .in_b   (b),
      .in_m   (m),
      .result (result),
      .done   (done),
      .busy   (busy)
    );

    initial begin : drv
      exp_t  e;
      word_t tm;
      int    guard;
      while (reset8) @(negedge clk);
      for (int k = 0; k < RAND_OPS; k++) begin
        tm = rand_word() >> $urandom_range(0, 508);
        if (tm == '0) tm = word_t'(1);
        a = rand_word() % tm;
        b = ($urandom_range(0, 15) == 0) ? a : rand_word() % tm;
        m = tm;
        start = 1'b1;
        e.res = ref_mod_sub(a, b, tm);
        e.lat = ref_latency(a, b, N8);
        // After a done the block spends one cycle in DONE, one in IDLE.
        e.start_edge = (k == 0) ? cyc + 1 : cyc + 2;
        q.push_back(e);
        guard = 0;
        do begin
          @(negedge clk);
          guard++;
        end while (!done && guard < 400);
        if (!done) begin
          check_int("lane8 done within budget", int'(done), 1);
          break;
        end
      end
      start = 1'b0;
      repeat (3) @(negedge clk);
      finished = 1'b1;
    end

    initial begin : mon
      exp_t e;
      bit   d_prev = 1'b0;
      forever begin
        @(negedge clk);
        if (done) begin
          check_int("lane8 done pulse width", int'(d_prev), 0);
          check_int("lane8 done with pending op", int'(q.size() > 0), 1);
          if (q.size() > 0) begin
            e = q.pop_front();
            check("lane8 result", result, e.res);
            check_int("lane8 done edge", cyc + 1, e.start_edge + e.lat);
          end
        end
        d_prev = done;
      end
    end
  end

  // ---------------- main sequence ----------------
  initial begin : main
    int    t0;
    word_t tm;
    repeat (3) @(negedge clk);
    check("reset result", s4_result, '0);
    check_int("reset busy", int'(s4_busy), 0);
    check_int("reset done", int'(s4_done), 0);
    reset4 = 1'b0;
    reset8 = 1'b0;

    run4(word_t'(5), word_t'(3), word_t'(7), 1'b1);
    run4(word_t'(3), word_t'(5), word_t'(7), 1'b0);
    run4(word_t'('h1234), word_t'('h1234), word_t'('hFFFF), 1'b0);
    run4('0, ~word_t'(1), '1, 1'b0);

    // Abort mid-SUB: no expectation is queued, so any done is flagged.
    s4_a = word_t'(9); s4_b = word_t'(4); s4_m = word_t'(11); s4_start = 1'b1;
    t0 = cyc + 1;
    @(negedge clk);
    s4_start = 1'b0;
    while (cyc < t0 + 59) @(negedge clk);
    reset4 = 1'b1;
    @(negedge clk);
    reset4 = 1'b0;
    check("abort result", s4_result, '0);
    check_int("abort busy", int'(s4_busy), 0);
    check_int("abort done", int'(s4_done), 0);
    run4(word_t'(9), word_t'(4), word_t'(11), 1'b0);

    for (int i = 0; i < 4; i++) begin
      tm = rand_word() | word_t'(1);
      run4(rand_word() % tm, rand_word() % tm, tm, 1'b0);
    end

    for (int i = 0; i < 90000 && !(g_rand[0].finished && g_rand[1].finished); i++)
      @(negedge clk);
    check_int("random lanes finished", int'(g_rand[0].finished && g_rand[1].finished), 1);
    check_int("lane4 outstanding ops", q4.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/mod_subtractor.md
MOD_SUBTRACTOR -- requirements
Module: mod_subtractor

Interface
REQ-001 The block SHALL have parameter CHUNK, default 4, giving the datapath chunk width in bits; legal values divide 512 (1, 2, 4, 8, 16, 32, 64).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request; sampled only in IDLE.
REQ-005 The block SHALL have port in_a, input, 512 bits: minuend, with in_a < in_m.
REQ-006 The block SHALL have port in_b, input, 512 bits: subtrahend, with in_b < in_m.
REQ-007 The block SHALL have port in_m, input, 512 bits: modulus, nonzero.
REQ-008 The block SHALL have port result, output, 512 bits: (in_a - in_b) mod in_m.
REQ-009 The block SHALL have port done, output, 1 bit: one-cycle pulse when result is valid.
REQ-010 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-011 The block SHALL use states IDLE, LOAD, SUB, ADD and DONE, with N = 512/CHUNK.
REQ-012 IDLE SHALL go to LOAD when start = 1, and SHALL stay in IDLE otherwise.
REQ-013 LOAD SHALL capture in_a, in_b and in_m into internal shift registers, clear the chunk counter, and set carry-in to 1 (two's-complement subtract), then go to SUB.
REQ-014 SUB SHALL, in each of N cycles, compute a_chunk + ~b_chunk + carry; it SHALL shift the CHUNK-bit sum into the MSB end of the result register and register the carry-out; on the Nth cycle the register SHALL hold a - b mod 2^512.
REQ-015 After the last SUB cycle, a final carry-out of 1 (no borrow, a >= b) SHALL go to DONE; a final carry-out of 0 (borrow) SHALL go to ADD with carry cleared and the operands reloaded as result-register / m.
REQ-016 ADD SHALL run N cycles computing r_chunk + m_chunk + carry into the result register, and the final carry-out SHALL be discarded; it then goes to DONE.
REQ-017 DONE SHALL assert done for exactly one cycle, then go to IDLE.
REQ-018 Latency: with start sampled at edge t0, done SHALL be high in cycle t0+N+2 when a >= b, and in cycle t0+2N+2 when a < b.
REQ-019 result SHALL hold its value from DONE until the next LOAD, and SHALL not change during IDLE.
REQ-020 start while busy = 1 SHALL be ignored, with no queueing.
REQ-021 in_a, in_b and in_m SHALL be sampled only in LOAD, and changes to them afterwards SHALL have no effect.
REQ-022 When a = b, the block SHALL take the no-borrow path and return 0.
REQ-023 The chunk counter SHALL be wide enough for N - 1 and SHALL wrap to 0 at each pass boundary.

Reset
REQ-024 While reset = 1 at a rising edge, state SHALL become IDLE and result, done, busy, carry, the counter and all shift registers SHALL become 0.
REQ-025 Reset asserted during any state SHALL abort the operation with no done pulse, and the block SHALL accept start in the first cycle after reset deasserts.

Structure
REQ-026 A shared package SHALL hold the state encoding (3-bit), the operand width constant 512, and the derived N and counter-width functions of CHUNK.
REQ-027 A single sub-module chunk_addsub SHALL implement the CHUNK-bit adder, with inputs x, y, cin and invert_y and outputs sum and cout.
REQ-028 The block SHALL instantiate one chunk_addsub, shared between the SUB and ADD passes.

Verification
REQ-029 Scenario 1: a=5, b=3, m=7, CHUNK=4 -> result=2, done high at t0+130, and exactly one done pulse.
REQ-030 Scenario 2: a=3, b=5, m=7 -> result=5, done high at t0+258.
REQ-031 Scenario 3: a=b=0x1234, m=0xFFFF -> result=0, done at t0+130.
REQ-032 Scenario 4: m=2^512-1, a=0, b=2^512-2 -> result=1, correction path taken.
REQ-033 Scenario 5: reset pulsed at t0+60 mid-SUB -> no done pulse, result=0, busy=0; a new start at the next cycle completes correctly.
REQ-034 Scenario 6: start held high throughout an operation with CHUNK=8 -> only one operation runs per IDLE visit, done occurs at t0+66 or t0+130, and the results match a reference model over 1000 random inputs with a,b < m.
